// File: rtl/ttl_pkg.sv
// Shared definitions for the parametrised TTL counter family.
// Latency: none (constants and elaboration-time helpers only).
// Backpressure: not applicable.
package ttl_pkg;

  // Count direction encodings for the 'up' input
  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  // Bits needed to represent states 0..m-1 (used to range-check MODULUS)
  function automatic int unsigned cnt_bits(input longint unsigned m);
    longint unsigned v;
    int unsigned     bits;
    bits = 0;
    v    = (m == 64'd0) ? 64'd0 : m - 64'd1;
    for (int i = 0; i < 64; i++) begin
      if (v != 64'd0) begin
        bits++;
        v = v >> 1;
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/ttl_tc_detect.sv
// Wide-AND terminal-count detector: flags q==MODULUS-1 and q==0.
// Latency: purely combinational.
// Backpressure: not applicable.
module ttl_tc_detect #(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic [WIDTH-1:0] q,
  output logic             tc_max,
  output logic             tc_zero
);
  import ttl_pkg::*;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  // Each bit matches its terminal pattern; the AND of all matches is the flag
  always_comb begin
    tc_max  = &(q ~^ MAX_VAL);
    tc_zero = &(~q);
  end

endmodule

// File: rtl/ttl_sync_counter.sv
// Synchronous up/down modulo-N counter with load, ENP/ENT enables and RCO.
// Latency: q updates one clk edge after rst/load/count; rco is combinational.
// Backpressure: none; cascade stages by wiring rco of one stage to ent of the next.
module ttl_sync_counter #(
  parameter int              WIDTH   = 4,
  parameter longint unsigned MODULUS = 64'd1 << WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             enp,
  input  logic             ent,
  input  logic             up,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rco
);
  import ttl_pkg::*;

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 64'd1);

  // Reject illegal widths and moduli at elaboration
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("ttl_sync_counter: WIDTH must be 1..32");
  end
  if (MODULUS < 64'd2 || cnt_bits(MODULUS) > WIDTH) begin : g_bad_modulus
    $error("ttl_sync_counter: MODULUS must be 2..2**WIDTH");
  end

  logic             tc_max;
  logic             tc_zero;
  logic [WIDTH-1:0] q_next;
  logic             over_range;

  ttl_tc_detect #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) u_tc (
    .q       (q),
    .tc_max  (tc_max),
    .tc_zero (tc_zero)
  );

  // Next-state mux: an out-of-range value wraps to 0 counting up, but
  // decrements normally counting down
  always_comb begin
    over_range = (64'(q) >= MODULUS);
    q_next     = q;
    if (up == CNT_UP) begin
      q_next = (tc_max || over_range) ? '0 : q + WIDTH'(1);
    end else begin
      q_next = tc_zero ? MAX_VAL : q - WIDTH'(1);
    end
  end

  // State register: reset beats load, load beats counting
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end else if (enp && ent) begin
      q <= q_next;
    end
  end

  // Ripple carry: terminal state for the current direction, gated by ent only
  always_comb begin
    rco = ent & ((up == CNT_UP) ? tc_max : tc_zero);
  end

endmodule

// File: tb/tb_ttl_sync_counter.sv
// Directed self-checking bench for ttl_sync_counter: decade, cascade, toggle.
module tb_ttl_sync_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Decade counter (WIDTH=4, MODULUS=10)
  logic       a_rst = 1'b1, a_load = 1'b0, a_enp = 1'b0, a_ent = 1'b0, a_up = 1'b0;
  logic [3:0] a_d = 4'd0;
  logic [3:0] a_q;
  logic       a_rco;

  ttl_sync_counter #(.WIDTH(4), .MODULUS(10)) u_dec (
    .clk(clk), .rst(a_rst), .load(a_load), .enp(a_enp), .ent(a_ent),
    .up(a_up), .d(a_d), .q(a_q), .rco(a_rco)
  );

  // Two cascaded binary stages
  logic       c_rst = 1'b1, c_enp = 1'b0, c_ent0 = 1'b0, c_up = 1'b1;
  logic [3:0] c_q0, c_q1;
  logic       c_rco0, c_rco1;

  ttl_sync_counter #(.WIDTH(4)) u_c0 (
    .clk(clk), .rst(c_rst), .load(1'b0), .enp(c_enp), .ent(c_ent0),
    .up(c_up), .d(4'd0), .q(c_q0), .rco(c_rco0)
  );
  ttl_sync_counter #(.WIDTH(4)) u_c1 (
    .clk(clk), .rst(c_rst), .load(1'b0), .enp(c_enp), .ent(c_rco0),
    .up(c_up), .d(4'd0), .q(c_q1), .rco(c_rco1)
  );

  // One-bit toggle counter
  logic t_rst = 1'b1, t_enp = 1'b0, t_ent = 1'b0, t_up = 1'b1;
  logic t_q, t_rco;

  ttl_sync_counter #(.WIDTH(1), .MODULUS(2)) u_tog (
    .clk(clk), .rst(t_rst), .load(1'b0), .enp(t_enp), .ent(t_ent),
    .up(t_up), .d(1'b0), .q(t_q), .rco(t_rco)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  initial begin
    logic [3:0] exp4;
    logic [7:0] exp8;

    // ---- decade counter: reset state ----
    step();
    chk("dec_rst_q", 32'(a_q), 32'd0);
    chk("dec_rst_rco_ent0", 32'(a_rco), 32'd0);
    a_ent = 1'b1; a_up = 1'b0; #1;
    chk("dec_rst_rco_down", 32'(a_rco), 32'd1);
    a_up = 1'b1; #1;
    chk("dec_rst_rco_up", 32'(a_rco), 32'd0);

    // ---- count up 12 clocks: 1..9,0,1,2 ----
    a_rst = 1'b0; a_enp = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      exp4 = 4'((i + 1) % 10);
      chk("dec_up_q", 32'(a_q), 32'(exp4));
      chk("dec_up_rco", 32'(a_rco), (exp4 == 4'd9) ? 32'd1 : 32'd0);
    end

    // ---- back to 0, ent=0 holds and masks rco ----
    a_rst = 1'b1; step(); a_rst = 1'b0;
    chk("dec_rst2_q", 32'(a_q), 32'd0);
    a_up = 1'b0; a_ent = 1'b0; #1;
    chk("dec_ent0_rco", 32'(a_rco), 32'd0);
    step();
    chk("dec_ent0_hold", 32'(a_q), 32'd0);
    a_ent = 1'b1; #1;
    chk("dec_zero_rco", 32'(a_rco), 32'd1);

    // ---- count down 3 clocks: 9,8,7 ----
    step(); chk("dec_dn_q9", 32'(a_q), 32'd9); chk("dec_dn_rco9", 32'(a_rco), 32'd0);
    step(); chk("dec_dn_q8", 32'(a_q), 32'd8);
    step(); chk("dec_dn_q7", 32'(a_q), 32'd7);
    a_enp = 1'b0; step();
    chk("dec_enp0_hold", 32'(a_q), 32'd7);

    // ---- out-of-range load, then up -> 0 ----
    a_load = 1'b1; a_d = 4'd13; a_ent = 1'b0; step();
    chk("dec_load13", 32'(a_q), 32'd13);
    a_load = 1'b0; a_enp = 1'b1; a_ent = 1'b1; a_up = 1'b1; #1;
    chk("dec_load13_rco_up", 32'(a_rco), 32'd0);
    step();
    chk("dec_oor_up", 32'(a_q), 32'd0);

    // ---- out-of-range load, then down -> 12 ----
    a_load = 1'b1; a_enp = 1'b0; step();
    chk("dec_load13b", 32'(a_q), 32'd13);
    a_load = 1'b0; a_enp = 1'b1; a_up = 1'b0; step();
    chk("dec_oor_down", 32'(a_q), 32'd12);

    // ---- rst beats load and count; load beats count ----
    a_rst = 1'b1; a_load = 1'b1; a_d = 4'd5; a_up = 1'b1; step();
    chk("dec_rst_prio", 32'(a_q), 32'd0);
    a_rst = 1'b0; step();
    chk("dec_load_prio", 32'(a_q), 32'd5);
    a_load = 1'b0; step();
    chk("dec_after_load", 32'(a_q), 32'd6);
    a_enp = 1'b0; a_ent = 1'b0;

    // ---- cascade: {q1,q0} tracks clocks mod 256 ----
    step();
    chk("cas_rst", 32'({c_q1, c_q0}), 32'd0);
    c_rst = 1'b0; c_enp = 1'b1; c_ent0 = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
      exp8 = 8'((i + 1) % 256);
      chk("cas_count", 32'({c_q1, c_q0}), 32'(exp8));
    end
    chk("cas_rco1", 32'(c_rco1), 32'd0);
    c_enp = 1'b0;

    // ---- 1-bit toggle with rst on cycle 5 ----
    step();
    chk("tog_rst", 32'(t_q), 32'd0);
    t_rst = 1'b0; t_enp = 1'b1; t_ent = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      step();
      chk("tog_q", 32'(t_q), 32'(i % 2));
    end
    t_rst = 1'b1; step(); t_rst = 1'b0;
    chk("tog_mid_rst", 32'(t_q), 32'd0);
    chk("tog_rco_zero_up", 32'(t_rco), 32'd0);
    step(); chk("tog_resume1", 32'(t_q), 32'd1);
    chk("tog_rco_max", 32'(t_rco), 32'd1);
    step(); chk("tog_resume0", 32'(t_q), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ttl_sync_counter.md
# ttl_sync_counter

Parametrised synchronous up/down counter for the TTL library, generalising the 74160/74161/74163 family to any width and any modulus, with added up/down count direction. It adds to the library's fixed-function chip models and is built from library primitives: a wide-AND terminal-count detector plus a registered state. Multiple instances cascade through ENT/RCO exactly as the discrete chips do.

## Interface
- WIDTH, 4, counter width in bits (1..32)
- MODULUS, 2**WIDTH, count length; states 0..MODULUS-1 (2..2**WIDTH)
- clk  input  1  rising-edge clock, the single clock of the block
- rst  input  1  reset, synchronous and active-high; clears q on the next clk edge
- load  input  1  synchronous parallel load of d, active-high
- enp  input  1  count enable (parallel), active-high
- ent  input  1  count enable (trickle), active-high; also gates rco
- up  input  1  direction: 1 = increment, 0 = decrement
- d  input  WIDTH  parallel load data
- q  output  WIDTH  counter state, registered
- rco  output  1  ripple carry out, combinational from q, ent, up

## Operation
- Actions on each clk rising edge, in priority order: rst -> q=0; else load -> q=d; else enp&ent -> count; else hold.
- Up count: q==MODULUS-1 or q>=MODULUS -> 0; otherwise q+1.
- Down count: q==0 -> MODULUS-1; otherwise q-1 (an out-of-range loaded value decrements normally).
- load accepts any d, including d>=MODULUS; no clamping.
- rco = ent & (up ? (q==MODULUS-1) : (q==0)); does not depend on enp, load or rst.
- Changing up between edges takes effect at the next edge; no other state.
- Cascade: the rco of stage k drives the ent of stage k+1, and enp is shared by all stages.

## Timing
- Reset value: q=0 one edge after rst is sampled high; rco then = ent & ~up (0 is terminal when counting down).
- Count, load and reset latency: 1 cycle; q updates only on clk edges.
- rco is valid combinationally within the same cycle as q/ent/up; there is no registered delay.
- Reset mid-count: rst overrides load and enables on that edge, and counting resumes from 0 on the first edge after rst falls.
- load and enp&ent asserted together: load wins and no increment is applied on that edge.
- No X propagation from d unless load=1.

## Structure
- Package ttl_pkg: the CNT_UP/CNT_DOWN direction constants and the count-width helper function used for MODULUS range checks.
- Sub-module ttl_tc_detect (WIDTH, MODULUS): a wide-AND equality detector that outputs tc_max (q==MODULUS-1) and tc_zero (q==0). It is the parametrised descendant of the multi-input AND chips.
- Top-level: next-state mux, q register, and rco AND.
- Elaboration check: MODULUS must be in the range 2..2**WIDTH.

## Test plan
- WIDTH=4, MODULUS=10, rst pulse, then enp=ent=up=1 for 12 clocks -> q steps 0..9,0,1,2; rco=1 only while q=9.
- Same config, up=0 from q=0 for 3 clocks -> q=9,8,7; rco=1 while q=0; ent=0 -> rco=0 and q holds.
- load=1 with d=13 (out of range), then count up once -> q=13, then 0; count down instead -> 13, 12.
- load=1, enp=ent=1, and rst=1 on the same edge -> q=0; next edge with rst=0 and load=1, d=5 -> q=5, with no increment.
- Two cascaded WIDTH=4 instances with default MODULUS, rco0->ent1, enp=1, up=1 for 300 clocks -> the combined {q1,q0} equals the clock count mod 256 on every cycle.
- WIDTH=1, MODULUS=2 toggle check, with rst asserted mid-run on cycle 5 -> q alternates 0,1 and is 0 on the edge after rst.
